// File: rtl/jtframe_sdram_arb_if.sv
// Bus bundle between game-side requesters, the SDRAM arbiter and the frame request port.
// The master view is the arbiter; the slave view is the environment (requesters plus frame).
interface jtframe_sdram_arb_if #(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned AW       = 22,
  parameter int unsigned DW       = 32
);
  logic                   loop_rst;
  logic [CHANNELS-1:0]    ch_req;
  logic [CHANNELS*AW-1:0] ch_addr;
  logic [CHANNELS*2-1:0]  ch_bank;
  logic [CHANNELS-1:0]    ch_rnw;
  logic [CHANNELS*2-1:0]  ch_wrmask;
  logic [CHANNELS*16-1:0] ch_wdata;
  logic [CHANNELS-1:0]    ch_ack;
  logic [CHANNELS-1:0]    ch_rdy;
  logic [DW-1:0]          ch_dout;
  logic                   sdram_req;
  logic [AW-1:0]          sdram_addr;
  logic [1:0]             sdram_bank;
  logic                   sdram_rnw;
  logic [1:0]             sdram_wrmask;
  logic [15:0]            data_write;
  logic                   sdram_ack;
  logic                   data_rdy;
  logic [DW-1:0]          data_read;
  logic                   busy;

  modport master (
    input  loop_rst, ch_req, ch_addr, ch_bank, ch_rnw, ch_wrmask, ch_wdata,
           sdram_ack, data_rdy, data_read,
    output ch_ack, ch_rdy, ch_dout, sdram_req, sdram_addr, sdram_bank,
           sdram_rnw, sdram_wrmask, data_write, busy
  );

  modport slave (
    output loop_rst, ch_req, ch_addr, ch_bank, ch_rnw, ch_wrmask, ch_wdata,
           sdram_ack, data_rdy, data_read,
    input  ch_ack, ch_rdy, ch_dout, sdram_req, sdram_addr, sdram_bank,
           sdram_rnw, sdram_wrmask, data_write, busy
  );
endinterface

// File: rtl/jtframe_sdram_arb.sv
// N-channel arbiter in front of the single frame SDRAM request port (clk_rom domain).
// One transaction in flight; fixed or round-robin priority; read data routed back to the owner.
module jtframe_sdram_arb #(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned AW       = 22,
  parameter int unsigned DW       = 32,
  parameter int unsigned RROBIN   = 1
) (
  input  logic clk_rom,
  input  logic rst_n,
  jtframe_sdram_arb_if.master bus
);
  localparam int unsigned PW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT} state_t;

  state_t                state;
  logic [PW-1:0]         owner;
  logic [PW-1:0]         ptr;
  logic [PW-1:0]         win;
  logic                  found;
  logic                  done;
  logic [CHANNELS-1:0]   owner_oh;
  int unsigned           idx;
  logic [AW-1:0]         sel_addr;
  logic [1:0]            sel_bank;
  logic                  sel_rnw;
  logic [1:0]            sel_mask;
  logic [15:0]           sel_wdata;

  // Winner search: starts at ptr in round-robin mode, at channel 0 otherwise
  always_comb begin
    win   = '0;
    found = 1'b0;
    idx   = 0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      idx = (RROBIN != 0) ? (32'(ptr) + i) % CHANNELS : i;
      if (!found && bus.ch_req[PW'(idx)]) begin
        found = 1'b1;
        win   = PW'(idx);
      end
    end
  end

  // Field mux for the winning channel
  always_comb begin
    sel_addr  = '0;
    sel_bank  = '0;
    sel_rnw   = 1'b0;
    sel_mask  = '0;
    sel_wdata = '0;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      if (win == PW'(k)) begin
        sel_addr  = bus.ch_addr[k*AW +: AW];
        sel_bank  = bus.ch_bank[k*2 +: 2];
        sel_rnw   = bus.ch_rnw[k];
        sel_mask  = bus.ch_wrmask[k*2 +: 2];
        sel_wdata = bus.ch_wdata[k*16 +: 16];
      end
    end
  end

  // A data_rdy coinciding with sdram_ack completes the transaction straight from REQ
  always_comb begin
    owner_oh = CHANNELS'(1) << owner;
    done     = ((state == ST_REQ) && bus.sdram_ack && bus.data_rdy) ||
               ((state == ST_WAIT) && bus.data_rdy);
  end

  always_ff @(posedge clk_rom) begin
    if (!rst_n) begin
      state            <= ST_IDLE;
      owner            <= '0;
      ptr              <= '0;
      bus.ch_ack       <= '0;
      bus.ch_rdy       <= '0;
      bus.ch_dout      <= '0;
      bus.sdram_req    <= 1'b0;
      bus.sdram_addr   <= '0;
      bus.sdram_bank   <= '0;
      bus.sdram_rnw    <= 1'b0;
      bus.sdram_wrmask <= '0;
      bus.data_write   <= '0;
      bus.busy         <= 1'b0;
    end else begin
      bus.ch_ack <= '0;
      bus.ch_rdy <= '0;
      case (state)
        ST_IDLE: begin
          if (!bus.loop_rst && found) begin
            owner            <= win;
            bus.sdram_addr   <= sel_addr;
            bus.sdram_bank   <= sel_bank;
            bus.sdram_rnw    <= sel_rnw;
            bus.sdram_wrmask <= sel_mask;
            bus.data_write   <= sel_wdata;
            bus.sdram_req    <= 1'b1;
            bus.busy         <= 1'b1;
            state            <= ST_REQ;
            if (RROBIN != 0)
              ptr <= (win == PW'(CHANNELS - 1)) ? '0 : win + PW'(1);
          end
        end
        ST_REQ: begin
          if (bus.sdram_ack) begin
            bus.sdram_req <= 1'b0;
            bus.ch_ack    <= owner_oh;
            state         <= ST_WAIT;
          end
        end
        ST_WAIT: ;
        default: state <= ST_IDLE;
      endcase
      // Completion overrides the REQ->WAIT move above
      if (done) begin
        if (bus.sdram_rnw) bus.ch_dout <= bus.data_read;
        bus.ch_rdy <= owner_oh;
        bus.busy   <= 1'b0;
        state      <= ST_IDLE;
      end
    end
  end
endmodule

// File: tb/tb_jtframe_sdram_arb.sv
// Lock-step bench for three arbiter instances: 4ch round-robin, 4ch fixed, 3ch round-robin.
// All share one requester/frame stimulus; a queue-free model predicts owner, fields and data.
module tb_jtframe_sdram_arb;
  localparam int unsigned AW = 22;
  localparam int unsigned DW = 32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        loop_rst, sack, drdy;
  logic [31:0] dread;
  logic [3:0]  req;
  logic [21:0] addr  [4];
  logic [1:0]  bank  [4];
  logic        rnw   [4];
  logic [1:0]  mask  [4];
  logic [15:0] wdata [4];
  logic [87:0] addr_v;
  logic [7:0]  bank_v, mask_v;
  logic [3:0]  rnw_v;
  logic [63:0] wdata_v;

  int total = 0, passed = 0, fails = 0;
  int ptr0, ptr2;
  logic [31:0] dout0_m, dout1_m, dout2_m;

  always #5 clk = ~clk;

  jtframe_sdram_arb_if #(.CHANNELS(4), .AW(AW), .DW(DW)) if0 ();
  jtframe_sdram_arb_if #(.CHANNELS(4), .AW(AW), .DW(DW)) if1 ();
  jtframe_sdram_arb_if #(.CHANNELS(3), .AW(AW), .DW(DW)) if2 ();

  jtframe_sdram_arb #(.CHANNELS(4), .AW(AW), .DW(DW), .RROBIN(1)) dut0 (.clk_rom(clk), .rst_n(rst_n), .bus(if0.master));
  jtframe_sdram_arb #(.CHANNELS(4), .AW(AW), .DW(DW), .RROBIN(0)) dut1 (.clk_rom(clk), .rst_n(rst_n), .bus(if1.master));
  jtframe_sdram_arb #(.CHANNELS(3), .AW(AW), .DW(DW), .RROBIN(1)) dut2 (.clk_rom(clk), .rst_n(rst_n), .bus(if2.master));

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      addr_v[k*22 +: 22]  = addr[k];
      bank_v[k*2 +: 2]    = bank[k];
      rnw_v[k]            = rnw[k];
      mask_v[k*2 +: 2]    = mask[k];
      wdata_v[k*16 +: 16] = wdata[k];
    end
  end

  assign if0.loop_rst = loop_rst;   assign if1.loop_rst = loop_rst;   assign if2.loop_rst = loop_rst;
  assign if0.ch_req = req;          assign if1.ch_req = req;          assign if2.ch_req = req[2:0];
  assign if0.ch_addr = addr_v;      assign if1.ch_addr = addr_v;      assign if2.ch_addr = addr_v[65:0];
  assign if0.ch_bank = bank_v;      assign if1.ch_bank = bank_v;      assign if2.ch_bank = bank_v[5:0];
  assign if0.ch_rnw = rnw_v;        assign if1.ch_rnw = rnw_v;        assign if2.ch_rnw = rnw_v[2:0];
  assign if0.ch_wrmask = mask_v;    assign if1.ch_wrmask = mask_v;    assign if2.ch_wrmask = mask_v[5:0];
  assign if0.ch_wdata = wdata_v;    assign if1.ch_wdata = wdata_v;    assign if2.ch_wdata = wdata_v[47:0];
  assign if0.sdram_ack = sack;      assign if1.sdram_ack = sack;      assign if2.sdram_ack = sack;
  assign if0.data_rdy = drdy;       assign if1.data_rdy = drdy;       assign if2.data_rdy = drdy;
  assign if0.data_read = dread;     assign if1.data_read = dread;     assign if2.data_read = dread;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Round-robin: first requester at or after p, wrapping at n
  function automatic int rr_pick(input logic [3:0] r, input int n, input int p);
    for (int k = 0; k < n; k++) begin
      int c;
      c = (p + k) % n;
      if (r[c]) return c;
    end
    return 0;
  endfunction

  function automatic int fx_pick(input logic [3:0] r);
    for (int k = 0; k < 4; k++)
      if (r[k]) return k;
    return 0;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic rand_ch(input int k);
    addr[k]  = 22'($urandom);
    bank[k]  = 2'($urandom);
    rnw[k]   = 1'($urandom);
    mask[k]  = 2'($urandom);
    wdata[k] = 16'($urandom);
  endtask

  task automatic wait_req();
    int n;
    n = 0;
    while (!(if0.sdram_req && if1.sdram_req && if2.sdram_req) && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("grant_req", 64'({if0.sdram_req, if1.sdram_req, if2.sdram_req}), 64'(3'b111));
  endtask

  // One full transaction on all three instances; called at a negedge
  task automatic step(input int ack_dly, input int rdy_dly, input bit same, input logic [31:0] rd,
                      input logic [3:0] keep, input bit drop_own, input logic [3:0] raise,
                      input bit ensure, input bit lr);
    int e0, e1, e2;
    bit g0, g1, g2;
    logic [3:0] ra, rr;
    e0 = rr_pick(req, 4, ptr0);
    e1 = fx_pick(req);
    e2 = rr_pick(req & 4'h7, 3, ptr2);
    ptr0 = (e0 + 1) % 4;
    ptr2 = (e2 + 1) % 3;
    g0 = rnw[e0]; g1 = rnw[e1]; g2 = rnw[e2];
    wait_req();
    chk("fields0", 64'({if0.sdram_addr, if0.sdram_bank, if0.sdram_rnw, if0.sdram_wrmask, if0.data_write}),
                   64'({addr[e0], bank[e0], rnw[e0], mask[e0], wdata[e0]}));
    chk("fields1", 64'({if1.sdram_addr, if1.sdram_rnw}), 64'({addr[e1], rnw[e1]}));
    chk("fields2", 64'({if2.sdram_addr, if2.sdram_rnw}), 64'({addr[e2], rnw[e2]}));
    chk("busy_req", 64'({if0.busy, if1.busy, if2.busy}), 64'(3'b111));
    repeat (ack_dly) begin
      @(negedge clk);
      chk("req_hold", 64'({if0.sdram_req, if0.sdram_addr}), 64'({1'b1, addr[e0]}));
    end
    sack = 1'b1;
    if (same) begin drdy = 1'b1; dread = rd; end
    @(negedge clk);
    sack = 1'b0; drdy = 1'b0;
    chk("ack0", 64'(if0.ch_ack), 64'(4'b0001 << e0));
    chk("ack1", 64'(if1.ch_ack), 64'(4'b0001 << e1));
    chk("ack2", 64'(if2.ch_ack), 64'(3'b001 << e2));
    chk("req_drop", 64'({if0.sdram_req, if1.sdram_req, if2.sdram_req}), 64'(3'b000));
    ra = req & keep;
    if (drop_own) ra[e0] = 1'b0;
    for (int k = 0; k < 4; k++)
      if (req[k] && !ra[k]) rand_ch(k);
    req = ra;
    loop_rst = lr;
    if (!same) begin
      repeat (rdy_dly) begin
        @(negedge clk);
        chk("wait_quiet", 64'({if0.ch_ack, if0.ch_rdy, if0.busy, if0.sdram_req}), 64'({4'b0, 4'b0, 1'b1, 1'b0}));
      end
      drdy = 1'b1; dread = rd;
      @(negedge clk);
      drdy = 1'b0;
    end
    if (g0) dout0_m = rd;
    if (g1) dout1_m = rd;
    if (g2) dout2_m = rd;
    chk("rdy0", 64'(if0.ch_rdy), 64'(4'b0001 << e0));
    chk("rdy1", 64'(if1.ch_rdy), 64'(4'b0001 << e1));
    chk("rdy2", 64'(if2.ch_rdy), 64'(3'b001 << e2));
    chk("dout0", 64'(if0.ch_dout), 64'(dout0_m));
    chk("dout1", 64'(if1.ch_dout), 64'(dout1_m));
    chk("dout2", 64'(if2.ch_dout), 64'(dout2_m));
    chk("idle_bubble", 64'({if0.busy, if1.busy, if2.busy, if0.sdram_req, if1.sdram_req, if2.sdram_req}), 64'(6'b0));
    rr = ra | raise;
    if (ensure && rr[2:0] == 3'b000) rr[0] = 1'b1;
    req = rr;
  endtask

  initial begin
    rst_n = 1'b0; loop_rst = 1'b0; sack = 1'b0; drdy = 1'b0; dread = '0;
    req = 4'hF;
    for (int k = 0; k < 4; k++) rand_ch(k);
    ptr0 = 0; ptr2 = 0;
    dout0_m = '0; dout1_m = '0; dout2_m = '0;

    // Reset held with every channel requesting
    repeat (3) begin
      @(negedge clk);
      chk("reset_ctl", 64'({if0.sdram_req, if0.ch_ack, if0.ch_rdy, if0.busy, if1.sdram_req, if1.busy,
                            if2.sdram_req, if2.busy, if1.ch_ack, if2.ch_ack}), 64'(0));
      chk("reset_dout", 64'({if0.ch_dout, if2.ch_dout}), 64'(0));
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk("req_after_reset", 64'({if0.sdram_req, if1.sdram_req, if2.sdram_req}), 64'(3'b111));

    // All channels held: round-robin rotates, fixed stays on ch0, 3ch wraps 2->0
    for (int i = 0; i < 5; i++)
      step(i % 3, 1 + i % 2, 1'b0, $urandom, (i == 4) ? 4'h0 : 4'hF, 1'b0, 4'h0, 1'b0, 1'b0);

    // Single read on ch2
    addr[2] = 22'h1234; rnw[2] = 1'b1; req = 4'b0100;
    step(2, 4, 1'b0, 32'hCAFE_F00D, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0);
    chk("read_ch2_data", 64'(if0.ch_dout), 64'(32'hCAFE_F00D));

    // Write on ch1 leaves ch_dout alone
    rnw[1] = 1'b0; mask[1] = 2'b01; wdata[1] = 16'hBEEF; req = 4'b0010;
    step(1, 2, 1'b0, 32'h1111_2222, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0);
    chk("write_dout_kept", 64'(if0.ch_dout), 64'(32'hCAFE_F00D));

    // sdram_ack and data_rdy together
    rnw[0] = 1'b1; req = 4'b0001;
    step(0, 0, 1'b1, 32'h5A5A_A5A5, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0);
    chk("same_cycle_data", 64'(if0.ch_dout), 64'(32'h5A5A_A5A5));

    // loop_rst raised in WAIT with ch1 still requesting
    rnw[1] = 1'b1; req = 4'b0010;
    step(1, 2, 1'b0, $urandom, 4'hF, 1'b0, 4'h0, 1'b0, 1'b1);
    repeat (4) begin
      @(negedge clk);
      chk("loop_rst_hold", 64'({if0.sdram_req, if1.sdram_req, if2.sdram_req, if0.busy, if1.busy, if2.busy}), 64'(0));
    end
    loop_rst = 1'b0;
    step(0, 1, 1'b0, $urandom, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0);

    // Reset during WAIT; a late data_rdy must be ignored
    rnw[2] = 1'b1; req = 4'b0100;
    wait_req();
    sack = 1'b1;
    @(negedge clk);
    sack = 1'b0; req = 4'h0;
    chk("rst_wait_ack", 64'(if0.ch_ack), 64'(4'b0100));
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_wait_idle", 64'({if0.busy, if1.busy, if2.busy, if0.sdram_req, if1.sdram_req, if2.sdram_req}), 64'(0));
    drdy = 1'b1; dread = 32'hDEAD_BEEF;
    @(negedge clk);
    drdy = 1'b0;
    chk("late_rdy_ignored", 64'({if0.ch_rdy, if1.ch_rdy, if2.ch_rdy, if0.busy}), 64'(0));
    chk("late_rdy_dout", 64'({if0.ch_dout, if1.ch_dout}), 64'(0));
    ptr0 = 0; ptr2 = 0;
    dout0_m = '0; dout1_m = '0; dout2_m = '0;

    // Randomized traffic against the model
    req = 4'($urandom) | 4'b0001;
    for (int t = 0; t < 30; t++)
      step($urandom_range(0, 3), $urandom_range(0, 4), ($urandom_range(0, 5) == 0), $urandom,
           4'hF, 1'($urandom), 4'($urandom), 1'b1, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
